// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control sequencer: steps FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// drives all state-dependent enables, counts retired instructions and traps on illegal opcodes/timeouts.
module riscv_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [6:0]           i_ctrl_opcode,
  input  logic                 i_take_branch,
  input  logic                 i_halt,
  input  logic                 i_mem_ack,
  output logic                 o_mem_req,
  output logic                 o_mem_wr_en,
  output logic                 o_mem_addr_src,
  output logic                 o_ir_wr_en,
  output logic                 o_pc_wr_en,
  output logic [1:0]           o_src_pc,
  output logic                 o_src_alu_a,
  output logic                 o_src_alu_b,
  output logic                 o_reg_wr_en,
  output logic [2:0]           o_state,
  output logic                 o_trap,
  output logic [1:0]           o_trap_cause,
  output logic [INSTRET_W-1:0] o_instret
);

  localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [TMO_W-1:0]       r_tmo;
  logic                   r_req_out;
  logic                   r_trap;
  logic [1:0]             r_cause;
  logic [INSTRET_W-1:0]   r_instret;
  logic                   w_retire;
  logic                   w_set_trap;
  logic [1:0]             w_cause;
  logic                   w_tmo_hit;
  logic                   w_legal;

  always_comb begin
    case (i_ctrl_opcode)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: w_legal = 1'b1;
      default:                               w_legal = 1'b0;
    endcase
  end

  // This cycle is the last unacknowledged one the request is allowed
  assign w_tmo_hit = (r_tmo == TMO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next_state   = r_state;
    w_retire       = 1'b0;
    w_set_trap     = 1'b0;
    w_cause        = 2'd0;
    o_mem_req      = 1'b0;
    o_mem_wr_en    = 1'b0;
    o_mem_addr_src = 1'b0;
    o_ir_wr_en     = 1'b0;
    o_pc_wr_en     = 1'b0;
    o_src_pc       = 2'd0;
    o_src_alu_a    = 1'b0;
    o_src_alu_b    = 1'b0;
    o_reg_wr_en    = 1'b0;
    case (r_state)
      S_FETCH: begin
        // Halt only idles before a request goes out; an issued fetch is held to ack
        if (!(i_halt && !r_req_out)) begin
          o_mem_req = 1'b1;
          if (i_mem_ack) begin
            o_ir_wr_en   = 1'b1;
            w_next_state = S_DECODE;
          end else if (w_tmo_hit) begin
            w_next_state = S_TRAP;
            w_set_trap   = 1'b1;
            w_cause      = 2'd2;
          end
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next_state = S_EXEC;
        end else begin
          w_next_state = S_TRAP;
          w_set_trap   = 1'b1;
          w_cause      = 2'd1;
        end
      end
      S_EXEC: begin
        case (i_ctrl_opcode)
          OPC_OPIMM, OPC_LOAD, OPC_STORE: o_src_alu_b = 1'b1;
          OPC_AUIPC: begin
            o_src_alu_a = 1'b1;
            o_src_alu_b = 1'b1;
          end
          default: ;
        endcase
        case (i_ctrl_opcode)
          OPC_LOAD, OPC_STORE: w_next_state = S_MEM;
          OPC_BRANCH: begin
            o_pc_wr_en   = 1'b1;
            o_src_pc     = i_take_branch ? 2'd1 : 2'd0;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end
          default: w_next_state = S_WB;
        endcase
      end
      S_MEM: begin
        o_mem_req      = 1'b1;
        o_mem_addr_src = 1'b1;
        o_mem_wr_en    = (i_ctrl_opcode == OPC_STORE);
        if (i_mem_ack) begin
          if (i_ctrl_opcode == OPC_STORE) begin
            o_pc_wr_en   = 1'b1;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WB;
          end
        end else if (w_tmo_hit) begin
          w_next_state = S_TRAP;
          w_set_trap   = 1'b1;
          w_cause      = 2'd3;
        end
      end
      S_WB: begin
        o_reg_wr_en  = 1'b1;
        o_pc_wr_en   = 1'b1;
        o_src_pc     = (i_ctrl_opcode == OPC_JAL)  ? 2'd1 :
                       (i_ctrl_opcode == OPC_JALR) ? 2'd2 : 2'd0;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_TRAP:  ;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_FETCH;
    else         r_state <= w_next_state;
  end

  // Wait-cycle counter and outstanding-request flag, both scoped to one state visit
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_tmo     <= '0;
      r_req_out <= 1'b0;
    end else if (w_next_state != r_state) begin
      r_tmo     <= '0;
      r_req_out <= 1'b0;
    end else if (o_mem_req && !i_mem_ack) begin
      r_tmo     <= r_tmo + TMO_W'(1);
      r_req_out <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_trap    <= 1'b0;
      r_cause   <= 2'd0;
      r_instret <= '0;
    end else begin
      if (w_set_trap) begin
        r_trap  <= 1'b1;
        r_cause <= w_cause;
      end
      if (w_retire) r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  assign o_state      = r_state;
  assign o_trap       = r_trap;
  assign o_trap_cause = r_cause;
  assign o_instret    = r_instret;

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core: a state machine steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a single shared instruction/data memory port.
- Sits beside the existing combinational decoder, which still supplies imm select, ALU op and rd source. This block owns every state-dependent enable: PC/IR latch, regfile write, memory request, address/ALU-operand muxes.
- Also counts retired instructions and traps on illegal opcodes or memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: max cycles a memory request may wait for ack before a trap; must be at least 2.
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- i_clk, input, 1: clock.
- i_rstn, input, 1: asynchronous active-low reset.
- i_ctrl_opcode, input, 7: opcode from IR.
- i_take_branch, input, 1: branch condition result from the datapath compare, valid in EXEC.
- i_halt, input, 1: stall request; honoured only at an instruction boundary.
- i_mem_ack, input, 1: memory completion; may be asserted in the same cycle as the request.
- o_mem_req, output, 1: memory request.
- o_mem_wr_en, output, 1: memory write qualifier, valid with o_mem_req.
- o_mem_addr_src, output, 1: 0 = PC, 1 = ALU result.
- o_ir_wr_en, output, 1: latch IR and old-PC.
- o_pc_wr_en, output, 1: PC update strobe.
- o_src_pc, output, 2: 0 = PC+4, 1 = oldPC+imm, 2 = rs1+imm.
- o_src_alu_a, output, 1: 0 = rs1, 1 = oldPC.
- o_src_alu_b, output, 1: 0 = rs2, 1 = imm.
- o_reg_wr_en, output, 1: regfile write strobe.
- o_state, output, 3: current state, for debug.
- o_trap, output, 1: sticky trap flag.
- o_trap_cause, output, 2: 0 = none, 1 = illegal opcode, 2 = fetch timeout, 3 = data timeout.
- o_instret, output, INSTRET_W: retired-instruction count.

Behaviour:
- Clock and reset: one clock; reset is asynchronous, active-low, on i_rstn.
- Reset values: state = FETCH (0), o_trap = 0, o_trap_cause = 0, o_instret = 0, timeout counter = 0, request-outstanding flag = 0.
- All enable/select outputs are combinational from state and inputs; every enable is 0 whenever a state does not drive it.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - If i_halt=1 and no request is outstanding: o_mem_req=0, stay in FETCH.
  - Otherwise: o_mem_req=1, o_mem_addr_src=0, o_mem_wr_en=0. Once issued, the request stays asserted until ack, regardless of i_halt.
  - On ack: o_ir_wr_en=1, go to DECODE.
- DECODE: one cycle.
  - Opcode not among the 9 RV32I classes (OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC): go to TRAP, cause=1.
  - Otherwise go to EXEC.
- EXEC: one cycle. ALU operand selects by opcode:
  - OP: a=rs1, b=rs2.
  - OP-IMM, LOAD, STORE: a=rs1, b=imm.
  - BRANCH: a=rs1, b=rs2.
  - AUIPC: a=oldPC, b=imm.
  - JAL, JALR, LUI: don't care, drive 0.
- EXEC next state:
  - LOAD, STORE: go to MEM.
  - BRANCH: o_pc_wr_en=1, o_src_pc = i_take_branch ? 1 : 0. The instruction retires; go to FETCH.
  - All others: go to WB.
- MEM:
  - o_mem_req=1, o_mem_addr_src=1, o_mem_wr_en = (STORE).
  - On ack, STORE: o_pc_wr_en=1, o_src_pc=0, retire, go to FETCH.
  - On ack, LOAD: go to WB.
- WB:
  - o_reg_wr_en=1 and o_pc_wr_en=1.
  - o_src_pc = 1 for JAL, 2 for JALR, 0 otherwise.
  - The datapath writes rd (oldPC+4 for jumps) and PC on the same edge.
  - Retire; go to FETCH.
- Retire: o_instret increments by 1 on the retiring edge and wraps modulo 2^INSTRET_W.
- Per-instruction latency with zero-wait memory: OP/OP-IMM/LUI/AUIPC/JAL/JALR = 4 cycles, LOAD = 5, STORE = 4, BRANCH = 3. Each memory wait cycle adds 1.
- Timeout counter:
  - Clears on every state change.
  - Counts cycles with o_mem_req=1 and i_mem_ack=0.
  - If the count reaches MEM_TIMEOUT without ack, go to TRAP on that edge: cause=2 from FETCH, 3 from MEM.
  - Ack in the same cycle the count would reach the limit wins (no trap).
- TRAP:
  - All enables 0, o_trap=1, cause held.
  - o_instret frozen; exit only by reset.
  - A pending request is dropped.
- Reset mid-instruction: immediate return to reset values. No PC or register write is issued for the aborted instruction.
- i_halt during DECODE/EXEC/MEM/WB has no effect; it applies only at the next FETCH.

Test Plan:
- Reset, then ADD (opcode 0110011) with ack tied 1 → states 0,1,2,4,0; o_reg_wr_en and o_pc_wr_en high only in WB with o_src_pc=0; o_instret=1 after 4 cycles.
- LW (0000011) with data ack delayed 2 cycles → MEM holds o_mem_req=1, addr_src=1, wr_en=0 for 3 cycles; total 7 cycles; one o_reg_wr_en pulse.
- BEQ (1100011) with i_take_branch=1, then again with 0 → 3 cycles each; o_src_pc = 1 then 0; o_reg_wr_en never asserted; o_instret +2.
- JALR (1100111) → WB cycle has o_src_pc=2 with o_reg_wr_en=1; a following SW (0100011) → MEM has o_mem_wr_en=1, retires 4 cycles after its FETCH.
- Opcode 0000000 → TRAP after DECODE with cause=1. Separately, fetch ack withheld → TRAP after exactly 16 request cycles with cause=2; ack arriving on the 16th cycle → no trap.
- i_halt=1 asserted while a fetch is outstanding → o_mem_req held until ack, then the next FETCH idles with o_mem_req=0. i_rstn pulsed low in MEM → outputs return to reset values asynchronously and o_instret=0.
